// File: rtl/issue_stage_pkg.sv
// Shared widths, bus layout and mode encoding for the single-entry issue stage.
package issue_stage_pkg;
  localparam int SEL1_WD    = 2;
  localparam int SEL2_WD    = 3;
  localparam int RADDR_WD   = 5;
  localparam int PC_WD      = 32;
  localparam int PAYLOAD_WD = 32;
  localparam int ID_TO_IS_BUS_WD = SEL1_WD + SEL2_WD + 2*RADDR_WD + PC_WD + PAYLOAD_WD;

  // Packed MSB-first, so the LSB-first bus layout reads bottom-up here.
  typedef struct packed {
    logic [PAYLOAD_WD-1:0] payload;
    logic [PC_WD-1:0]      pc;
    logic [RADDR_WD-1:0]   raddr2;
    logic [RADDR_WD-1:0]   raddr1;
    logic [SEL2_WD-1:0]    sel2;
    logic [SEL1_WD-1:0]    sel1;
  } is_bus_t;

  typedef enum logic [1:0] {
    MODE_EMPTY = 2'd0,
    MODE_WAIT  = 2'd1,
    MODE_BLOCK = 2'd2,
    MODE_GO    = 2'd3
  } is_mode_e;
endpackage

// File: rtl/issue_stage.sv
// Single-entry ID->EXE issue register with valid/allowin handshake and branch flush.
// Optional stall counter enabled by defining ISSUE_STALL_CNT_EN.
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int STALL_CNT_WD = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ID_to_IS_valid,
  output logic                       IS_allowin,
  input  logic [ID_TO_IS_BUS_WD-1:0] ID_to_IS_bus,
  output logic [SEL1_WD-1:0]         sel_alu_bu_src1,
  output logic [SEL2_WD-1:0]         sel_alu_bu_src2,
  output logic [RADDR_WD-1:0]        RegFile_R_addr1,
  output logic [RADDR_WD-1:0]        RegFile_R_addr2,
  input  logic                       src_1_ready,
  input  logic                       src_2_ready,
  input  logic                       EXE_allowin,
  output logic                       IS_to_EXE_valid,
  output logic [ID_TO_IS_BUS_WD-1:0] IS_to_EXE_bus,
`ifdef ISSUE_STALL_CNT_EN
  output logic [STALL_CNT_WD-1:0]    stall_cnt,
`endif
  input  logic                       br_flush
);

  logic    is_valid;
  is_bus_t is_bus;
  logic    ready_go;

  assign ready_go        = src_1_ready & src_2_ready;
  assign IS_allowin      = ~is_valid | (ready_go & EXE_allowin);
  assign IS_to_EXE_valid = is_valid & ready_go & ~br_flush;
  assign IS_to_EXE_bus   = is_bus;

  // Zero selects while empty so WakeUP reports ready and never blocks allowin.
  assign sel_alu_bu_src1 = is_valid ? is_bus.sel1 : '0;
  assign sel_alu_bu_src2 = is_valid ? is_bus.sel2 : '0;
  assign RegFile_R_addr1 = is_bus.raddr1;
  assign RegFile_R_addr2 = is_bus.raddr2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_valid <= 1'b0;
      is_bus   <= '0;
    end else if (br_flush) begin
      is_valid <= 1'b0;
    end else if (IS_allowin) begin
      is_valid <= ID_to_IS_valid;
      if (ID_to_IS_valid) is_bus <= ID_to_IS_bus;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  is_mode_e mode;

  always_comb begin
    mode = MODE_EMPTY;
    if (is_valid) begin
      if (!ready_go)        mode = MODE_WAIT;
      else if (EXE_allowin) mode = MODE_GO;
      else                  mode = MODE_BLOCK;
    end
  end

  // Saturating: a long stall should read as "huge", never wrap to small.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cnt <= '0;
    else if ((mode == MODE_WAIT || mode == MODE_BLOCK) && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule
